// File: rtl/rc_servo_core_multi_if.sv
`default_nettype none
// ============================================================================
//  Module   : rc_servo_core_multi_if
//  Purpose  : Bundles the run control, comparator inputs and servo outputs of
//             rc_servo_core_multi into one interface.
//  Signals  : ena           run enable (0 = counters held, outputs low)
//             comp_async_i  async comparator per channel (1 = widen pulse)
//             hold_i        per-channel freeze of the pulse width
//             pwm_o         registered servo PWM per channel
//             frame_o       1-clk pulse at the start of each frame
//             at_limit_o    per-channel flag: width sits at PW_MIN or PW_MAX
//             pw_o          packed pulse widths, ch i at [i*CNT_W +: CNT_W]
//  Modports : master (drives controls, observes outputs), slave (the core)
//  Revision : 1.0  initial release
// ============================================================================
interface rc_servo_core_multi_if #(
   parameter int N_CH  = 2,
   parameter int CNT_W = 15
);
   logic                    ena;
   logic [N_CH-1:0]         comp_async_i;
   logic [N_CH-1:0]         hold_i;
   logic [N_CH-1:0]         pwm_o;
   logic                    frame_o;
   logic [N_CH-1:0]         at_limit_o;
   logic [N_CH*CNT_W-1:0]   pw_o;

   modport master (
      output ena, comp_async_i, hold_i,
      input  pwm_o, frame_o, at_limit_o, pw_o
   );

   modport slave (
      input  ena, comp_async_i, hold_i,
      output pwm_o, frame_o, at_limit_o, pw_o
   );
endinterface
`default_nettype wire

// File: rtl/rc_servo_core_multi.sv
`default_nettype none
// ============================================================================
//  Module   : rc_servo_core_multi
//  Purpose  : N-channel bang-bang RC-servo core. A shared prescaler and frame
//             counter generate the PWM frame; each channel steps its pulse
//             width up or down by STEP once per frame according to its
//             synchronised comparator, clamped to [PW_MIN, PW_MAX].
//  Ports    : clk    system clock
//             rst_n  synchronous active-low reset
//             bus    rc_servo_core_multi_if.slave (controls in, servo outs)
//  Revision : 1.0  initial release
// ============================================================================
module rc_servo_core_multi #(
   parameter int N_CH        = 2,
   parameter int CNT_W       = 15,
   parameter int PRESCALE    = 50,
   parameter int FRAME_TICKS = 20000,
   parameter int PW_MIN      = 1000,
   parameter int PW_MAX      = 2000,
   parameter int PW_CENTER   = 1500,
   parameter int STEP        = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rc_servo_core_multi_if.slave bus
);

   localparam int              PS_W       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST    = PS_W'(PRESCALE - 1);
   localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_TICKS - 1);
   localparam logic [CNT_W-1:0] PW_MIN_C   = CNT_W'(PW_MIN);
   localparam logic [CNT_W-1:0] PW_MAX_C   = CNT_W'(PW_MAX);
   localparam logic [CNT_W-1:0] PW_CTR_C   = CNT_W'(PW_CENTER);
   localparam logic [CNT_W-1:0] STEP_C     = CNT_W'(STEP);
   // Extended-width clamp thresholds so the step arithmetic cannot wrap
   localparam logic [CNT_W:0]   PW_MAX_X   = (CNT_W+1)'(PW_MAX);
   localparam logic [CNT_W:0]   STEP_X     = (CNT_W+1)'(STEP);
   localparam logic [CNT_W:0]   DN_FLOOR_X = (CNT_W+1)'(PW_MIN + STEP);

   logic [PS_W-1:0]        prescaler;
   logic [CNT_W-1:0]       frame_cnt;
   logic                   frame_pulse;
   logic                   tick;
   logic                   frame_end;

   logic [N_CH-1:0]        pwm_bits;
   logic [N_CH-1:0]        limit_bits;
   logic [N_CH*CNT_W-1:0]  pw_bits;

   // tick is gated by ena so a PRESCALE of 1 cannot advance a stopped frame
   assign tick      = bus.ena && (prescaler == PS_LAST);
   assign frame_end = tick && (frame_cnt == FRAME_LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prescaler   <= '0;
         frame_cnt   <= '0;
         frame_pulse <= 1'b0;
      end else if (!bus.ena) begin
         prescaler   <= '0;
         frame_cnt   <= '0;
         frame_pulse <= 1'b0;
      end else begin
         prescaler   <= tick ? '0 : prescaler + 1'b1;
         if (tick) begin
            frame_cnt <= frame_end ? '0 : frame_cnt + 1'b1;
         end
         // Marks the edge on which frame_cnt returns to 0
         frame_pulse <= frame_end;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      logic [1:0]       sync;
      logic [CNT_W-1:0] pw;
      logic             pwm;
      logic             at_lim;
      logic [CNT_W:0]   pw_up;
      logic [CNT_W-1:0] pw_next_up;
      logic [CNT_W-1:0] pw_next_dn;

      always_comb begin
         pw_up      = {1'b0, pw} + STEP_X;
         pw_next_up = (pw_up > PW_MAX_X) ? PW_MAX_C : pw_up[CNT_W-1:0];
         pw_next_dn = ({1'b0, pw} < DN_FLOOR_X) ? PW_MIN_C : (pw - STEP_C);
      end

      always_ff @(posedge clk) begin
         if (!rst_n) begin
            sync   <= 2'b00;
            pw     <= PW_CTR_C;
            pwm    <= 1'b0;
            at_lim <= 1'b0;
         end else begin
            sync   <= {sync[0], bus.comp_async_i[i]};
            pwm    <= bus.ena && (frame_cnt < pw);
            at_lim <= (pw == PW_MIN_C) || (pw == PW_MAX_C);
            // Width only moves on the last clk of a frame, so the pulse in
            // progress is never reshaped and the new width starts at count 0
            if (frame_end && !bus.hold_i[i]) begin
               pw <= sync[1] ? pw_next_up : pw_next_dn;
            end
         end
      end

      assign pwm_bits[i]                 = pwm;
      assign limit_bits[i]               = at_lim;
      assign pw_bits[i*CNT_W +: CNT_W]   = pw;
   end

   assign bus.pwm_o      = pwm_bits;
   assign bus.frame_o    = frame_pulse;
   assign bus.at_limit_o = limit_bits;
   assign bus.pw_o       = pw_bits;

endmodule
`default_nettype wire

// File: tb/tb_rc_servo_core_multi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rc_servo_core_multi
//  Purpose  : Self-checking bench for rc_servo_core_multi using small test
//             parameters; a time-based reference model plus directed checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rc_servo_core_multi;

   localparam int N_CH   = 2;
   localparam int CNT_W  = 15;
   localparam int P      = 2;
   localparam int F      = 20;
   localparam int PWMIN  = 4;
   localparam int PWMAX  = 10;
   localparam int PWCTR  = 7;
   localparam int STP    = 2;
   localparam int FRAME_CLKS = P * F;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   rc_servo_core_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

   rc_servo_core_multi #(
      .N_CH(N_CH), .CNT_W(CNT_W), .PRESCALE(P), .FRAME_TICKS(F),
      .PW_MIN(PWMIN), .PW_MAX(PWMAX), .PW_CENTER(PWCTR), .STEP(STP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (time-based) ----------------
   // Position in the frame is derived from clocks elapsed since run start.
   int              elapsed;
   int              pw_m [N_CH];
   logic [N_CH-1:0] s1_m, s2_m, pwm_m, atl_m;
   logic            frame_m;

   task automatic model_step();
      int fc, pr;
      if (!rst_n) begin
         elapsed = 0;
         for (int i = 0; i < N_CH; i++) pw_m[i] = PWCTR;
         s1_m = '0; s2_m = '0; pwm_m = '0; atl_m = '0; frame_m = 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++)
            atl_m[i] = (pw_m[i] == PWMIN) || (pw_m[i] == PWMAX);
         if (bus.ena) begin
            pr = elapsed % P;
            fc = (elapsed / P) % F;
            for (int i = 0; i < N_CH; i++) pwm_m[i] = (fc < pw_m[i]);
            frame_m = (pr == P-1) && (fc == F-1);
            if (frame_m) begin
               for (int i = 0; i < N_CH; i++) begin
                  if (!bus.hold_i[i]) begin
                     if (s2_m[i]) pw_m[i] = (pw_m[i] + STP > PWMAX) ? PWMAX : pw_m[i] + STP;
                     else         pw_m[i] = (pw_m[i] - STP < PWMIN) ? PWMIN : pw_m[i] - STP;
                  end
               end
            end
            elapsed++;
         end else begin
            elapsed = 0; pwm_m = '0; frame_m = 1'b0;
         end
         s2_m = s1_m;
         s1_m = bus.comp_async_i;
      end
   endtask

   always @(posedge clk) begin
      model_step();
      #1;
      check("model_pwm", 64'(bus.pwm_o), 64'(pwm_m));
      check("model_frame", 64'(bus.frame_o), 64'(frame_m));
      check("model_atl", 64'(bus.at_limit_o), 64'(atl_m));
      for (int i = 0; i < N_CH; i++)
         check("model_pw", 64'(bus.pw_o[i*CNT_W +: CNT_W]), 64'(pw_m[i]));
   end

   // ---------------- directed helpers ----------------
   task automatic wait_frame();
      int n = 0;
      while (!bus.frame_o && n < 4*FRAME_CLKS) begin
         @(negedge clk);
         n++;
      end
      if (!bus.frame_o) check("frame_timeout", 64'(bus.frame_o), 64'd1);
   endtask

   // Counts PWM high clocks over one frame, starting at a frame_o sample
   task automatic count_frame(output int c0, output int c1);
      c0 = 0; c1 = 0;
      for (int k = 0; k < FRAME_CLKS; k++) begin
         @(negedge clk);
         c0 += int'(bus.pwm_o[0]);
         c1 += int'(bus.pwm_o[1]);
      end
   endtask

   function automatic int pw_of(input int ch);
      return int'(bus.pw_o[ch*CNT_W +: CNT_W]);
   endfunction

   initial begin
      int c0, c1, gap;
      bus.ena = 1'b0; bus.comp_async_i = '0; bus.hold_i = '0;
      repeat (3) @(negedge clk);
      check("reset_pwm", 64'(bus.pwm_o), 64'd0);
      check("reset_frame", 64'(bus.frame_o), 64'd0);
      check("reset_atl", 64'(bus.at_limit_o), 64'd0);
      check("reset_pw", 64'(bus.pw_o), {34'd0, 15'd7, 15'd7});

      // 1: centred widths, 14 high clks per 40, frame every 40 clks
      rst_n = 1'b1; bus.ena = 1'b1; bus.hold_i = 2'b11;
      wait_frame();
      count_frame(c0, c1);
      check("s1_high0", 64'(c0), 64'd14);
      check("s1_high1", 64'(c1), 64'd14);
      check("s1_frame_period", 64'(bus.frame_o), 64'd1);

      // 5: comparator rises mid-pulse; current pulse unchanged, next +4
      bus.hold_i = 2'b10; bus.comp_async_i = 2'b00;
      c0 = 0;
      for (int k = 0; k < FRAME_CLKS; k++) begin
         @(negedge clk);
         c0 += int'(bus.pwm_o[0]);
         if (k == 5) bus.comp_async_i[0] = 1'b1;
      end
      check("s5_cur_pulse", 64'(c0), 64'd14);
      count_frame(c0, c1);
      check("s5_next_pulse", 64'(c0), 64'd18);

      // 2/3: ch0 up to PW_MAX, ch1 down to PW_MIN
      bus.hold_i = 2'b00; bus.comp_async_i = 2'b01;
      repeat (4) begin wait_frame(); @(negedge clk); end
      wait_frame();
      check("s2_pw0_max", 64'(pw_of(0)), 64'd10);
      check("s3_pw1_min", 64'(pw_of(1)), 64'd4);
      check("s23_atl", 64'(bus.at_limit_o), 64'd3);
      count_frame(c0, c1);
      check("s2_high0", 64'(c0), 64'd20);
      check("s3_high1", 64'(c1), 64'd8);

      // 4: ch0 held while its comparator toggles; ch1 climbs 4->10
      bus.hold_i = 2'b01; bus.comp_async_i = 2'b10;
      for (int f = 0; f < 3; f++) begin
         wait_frame();
         bus.comp_async_i[0] = ~bus.comp_async_i[0];
         @(negedge clk);
      end
      wait_frame();
      check("s4_pw0_held", 64'(pw_of(0)), 64'd10);
      check("s4_pw1_upd", 64'(pw_of(1)), 64'd10);

      // 6: reset for one clk mid-pulse, then ena=0 retention
      @(negedge clk); @(negedge clk);
      check("s6_pulse_high", 64'(bus.pwm_o), 64'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("s6_rst_pwm", 64'(bus.pwm_o), 64'd0);
      check("s6_rst_pw", 64'(bus.pw_o), {34'd0, 15'd7, 15'd7});
      bus.hold_i = 2'b00; bus.comp_async_i = 2'b10;
      wait_frame(); @(negedge clk); wait_frame(); @(negedge clk); wait_frame();
      // pw0 7->5->4 (first update sees comp0=0), pw1 7->9->10
      check("s6_pw_after", 64'(bus.pw_o), {34'd0, 15'd10, 15'd4});
      bus.ena = 1'b0;
      repeat (FRAME_CLKS + 3) @(negedge clk);
      check("s6_ena0_pwm", 64'(bus.pwm_o), 64'd0);
      check("s6_ena0_frame", 64'(bus.frame_o), 64'd0);
      check("s6_ena0_pw", 64'(bus.pw_o), {34'd0, 15'd10, 15'd4});
      bus.ena = 1'b1;
      gap = 0;
      while (!bus.frame_o && gap < 4*FRAME_CLKS) begin @(negedge clk); gap++; end
      check("s6_first_frame", 64'(gap), 64'(FRAME_CLKS));

      // Random phase: async comparator edges, hold/ena toggles, rare resets
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 99) < 4) bus.comp_async_i[$urandom_range(0, N_CH-1)] ^= 1'b1;
         if ($urandom_range(0, 199) < 1) bus.hold_i = N_CH'($urandom_range(0, 3));
         if ($urandom_range(0, 499) < 1) bus.ena = ~bus.ena;
         if (!bus.ena && $urandom_range(0, 19) < 1) bus.ena = 1'b1;
         rst_n = ($urandom_range(0, 999) != 0);
      end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
